// File: rtl/op_result_scanner_pkg.sv
// op_result_scanner_pkg: shared widths, field indices and FSM encoding for the result scanner.
package op_result_scanner_pkg;
  localparam int W = 4;
  localparam int NFIELDS = 9;
  localparam int ARITH_IDX = 0;
  localparam int SHIFT_IDX = 1;
  localparam int REL_IDX = 2;
  localparam int EQ_IDX = 3;
  localparam int BITW_IDX = 4;
  localparam int RED_IDX = 5;
  localparam int LOG_IDX = 6;
  localparam int CONCAT_IDX = 7;
  localparam int COND_IDX = 8;
  localparam int CSUM_IDX = 9;
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
  function automatic logic [W-1:0] xor_fold(input logic [NFIELDS-1:0][W-1:0] f);
    logic [W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NFIELDS; i++) acc = acc ^ f[i];
    return acc;
  endfunction
endpackage

// File: rtl/op_result_scanner_if.sv
// op_result_scanner_if: capture request, result fields and the beat stream of the scanner.
interface op_result_scanner_if import op_result_scanner_pkg::*;;
  logic capture;
  logic [W-1:0] arithmetic, shift, relational, equality, bitwise;
  logic [W-1:0] reduction, logical, concatenation, conditional;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_data;
  logic [3:0] out_index;
  logic out_last;
  logic busy;
  logic done;
  modport master(
    output capture, arithmetic, shift, relational, equality, bitwise,
           reduction, logical, concatenation, conditional, out_ready,
    input out_valid, out_data, out_index, out_last, busy, done
  );
  modport slave(
    input capture, arithmetic, shift, relational, equality, bitwise,
          reduction, logical, concatenation, conditional, out_ready,
    output out_valid, out_data, out_index, out_last, busy, done
  );
endinterface

// File: rtl/scan_field_mux.sv
// scan_field_mux: selects the latched field addressed by the beat index.
module scan_field_mux import op_result_scanner_pkg::*; (
  input  logic [NFIELDS-1:0][W-1:0] fields,
  input  logic [3:0]                idx,
  output logic [W-1:0]              data
);
  assign data = idx < 4'(NFIELDS) ? fields[idx] : '0;
endmodule

// File: rtl/op_result_scanner.sv
// op_result_scanner: latches nine result fields on capture and streams them plus an XOR checksum.
module op_result_scanner import op_result_scanner_pkg::*; (
  input logic clk,
  input logic rst,
  op_result_scanner_if.slave bus
);
  state_t state;
  logic [NFIELDS-1:0][W-1:0] fields, in_fields;
  logic [W-1:0] csum, field_data;
  logic xfer;
  assign in_fields = {bus.conditional, bus.concatenation, bus.logical, bus.reduction,
                      bus.bitwise, bus.equality, bus.relational, bus.shift, bus.arithmetic};
  assign xfer = bus.out_valid && bus.out_ready;
  scan_field_mux u_mux (.fields(fields), .idx(bus.out_index), .data(field_data));
  // Payload is zero whenever no beat is offered, even though fields stay latched.
  assign bus.out_data = !bus.out_valid ? '0 : bus.out_last ? csum : field_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      fields <= '0;
      csum <= '0;
      bus.out_valid <= 1'b0;
      bus.out_index <= '0;
      bus.out_last <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.capture) begin
          state <= SEND;
          fields <= in_fields;
          csum <= xor_fold(in_fields);
          bus.out_valid <= 1'b1;
          bus.out_index <= 4'(ARITH_IDX);
          bus.busy <= 1'b1;
        end
        SEND: if (xfer) begin
          if (bus.out_index == 4'(COND_IDX)) begin
            state <= CSUM;
            bus.out_index <= 4'(CSUM_IDX);
            bus.out_last <= 1'b1;
          end else begin
            bus.out_index <= bus.out_index + 4'd1;
          end
        end
        CSUM: if (xfer) begin
          state <= IDLE;
          bus.out_valid <= 1'b0;
          bus.out_index <= '0;
          bus.out_last <= 1'b0;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_op_result_scanner.sv
// tb_op_result_scanner: directed scenarios with hand-computed beat streams and checksums.
module tb_op_result_scanner;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] f [9];
  int n_cmp = 0;
  int n_err = 0;
  op_result_scanner_if bus();
  op_result_scanner dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.arithmetic = f[0];
  assign bus.shift = f[1];
  assign bus.relational = f[2];
  assign bus.equality = f[3];
  assign bus.bitwise = f[4];
  assign bus.reduction = f[5];
  assign bus.logical = f[6];
  assign bus.concatenation = f[7];
  assign bus.conditional = f[8];

  task automatic test_reset();
    rst = 1'b1;
    bus.capture = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) f[i] = 4'hA;
    #2;
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.out_index, bus.out_last, bus.busy, bus.done} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_async: got v=%b d=%h i=%0d l=%b b=%b dn=%b want all 0", bus.out_valid, bus.out_data, bus.out_index, bus.out_last, bus.busy, bus.done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.out_index, bus.out_last, bus.busy, bus.done} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_idle: got v=%b d=%h i=%0d l=%b b=%b dn=%b want all 0", bus.out_valid, bus.out_data, bus.out_index, bus.out_last, bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    logic [3:0] exp_d;
    for (int i = 0; i < 9; i++) f[i] = 4'(i + 1);
    bus.out_ready = 1'b1;
    bus.capture = 1'b1;
    @(negedge clk);
    bus.capture = 1'b0;
    for (int b = 0; b < 10; b++) begin
      exp_d = b < 9 ? 4'(b + 1) : 4'h1;
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_index !== 4'(b) || bus.out_data !== exp_d || bus.out_last !== (b == 9) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL basic_beat%0d: got v=%b i=%0d d=%h l=%b b=%b dn=%b want v=1 i=%0d d=%h l=%b b=1 dn=0", b, bus.out_valid, bus.out_index, bus.out_data, bus.out_last, bus.busy, bus.done, b, exp_d, b == 9);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.out_index !== 4'h0) begin
      n_err++;
      $display("FAIL basic_done: got dn=%b b=%b v=%b d=%h i=%0d want dn=1 b=0 v=0 d=0 i=0", bus.done, bus.busy, bus.out_valid, bus.out_data, bus.out_index);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_width: got dn=%b want 0", bus.done);
    end
  endtask

  task automatic test_backpressure();
    int exp_i;
    int c;
    for (int i = 0; i < 9; i++) f[i] = 4'hC;
    bus.capture = 1'b1;
    @(negedge clk);
    bus.capture = 1'b0;
    exp_i = 0;
    c = 0;
    while (exp_i < 10 && c < 60) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_index !== 4'(exp_i) || bus.out_data !== 4'hC || bus.out_last !== (exp_i == 9) || bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL bp_cycle%0d: got v=%b i=%0d d=%h l=%b dn=%b want v=1 i=%0d d=c l=%b dn=0", c, bus.out_valid, bus.out_index, bus.out_data, bus.out_last, bus.done, exp_i, exp_i == 9);
      end
      bus.out_ready = (c % 3 == 0);
      @(negedge clk);
      if (bus.out_ready) exp_i++;
      c++;
    end
    n_cmp++;
    if (exp_i != 10 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_done: got beats=%0d dn=%b b=%b want beats=10 dn=1 b=0", exp_i, bus.done, bus.busy);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_capture_busy();
    logic [3:0] exp_d;
    int dones;
    for (int i = 0; i < 9; i++) f[i] = 4'(i + 3);
    bus.capture = 1'b1;
    @(negedge clk);
    bus.capture = 1'b0;
    for (int b = 0; b < 10; b++) begin
      exp_d = b < 9 ? 4'(b + 3) : 4'h3;
      n_cmp++;
      if (bus.out_index !== 4'(b) || bus.out_data !== exp_d) begin
        n_err++;
        $display("FAIL busy_beat%0d: got i=%0d d=%h want i=%0d d=%h", b, bus.out_index, bus.out_data, b, exp_d);
      end
      if (b == 4) begin
        bus.capture = 1'b1;
        for (int i = 0; i < 9; i++) f[i] = 4'hF;
      end else begin
        bus.capture = 1'b0;
      end
      @(negedge clk);
    end
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.done === 1'b1) dones++;
      n_cmp++;
      if (bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL busy_not_queued%0d: got b=%b want 0", k, bus.busy);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (dones != 1) begin
      n_err++;
      $display("FAIL busy_done_count: got %0d want 1", dones);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    for (int i = 0; i < 9; i++) f[i] = 4'(i + 1);
    bus.capture = 1'b1;
    @(negedge clk);
    bus.capture = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (bus.out_index !== 4'd5 || bus.out_data !== 4'h6) begin
      n_err++;
      $display("FAIL rstmid_pre: got i=%0d d=%h want i=5 d=6", bus.out_index, bus.out_data);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.out_index, bus.out_last, bus.busy, bus.done} !== 12'h0) begin
      n_err++;
      $display("FAIL rstmid_async: got v=%b d=%h i=%0d l=%b b=%b dn=%b want all 0", bus.out_valid, bus.out_data, bus.out_index, bus.out_last, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
      @(negedge clk);
    end
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL rstmid_no_done: got %0d active cycles want 0", dones);
    end
    for (int i = 0; i < 9; i++) f[i] = 4'(8 - i);
    bus.capture = 1'b1;
    @(negedge clk);
    bus.capture = 1'b0;
    for (int b = 0; b < 2; b++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_index !== 4'(b) || bus.out_data !== 4'(8 - b)) begin
        n_err++;
        $display("FAIL rstmid_restart%0d: got v=%b i=%0d d=%h want v=1 i=%0d d=%h", b, bus.out_valid, bus.out_index, bus.out_data, b, 4'(8 - b));
      end
      @(negedge clk);
    end
    repeat (9) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_drain: got b=%b want 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 9; i++) f[i] = 4'(i + 1);
    bus.capture = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      n_cmp++;
      if (bus.out_index !== 4'(b) || bus.out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_beat%0d: got v=%b i=%0d want v=1 i=%0d", b, bus.out_valid, bus.out_index, b);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_done: got dn=%b b=%b want dn=1 b=0", bus.done, bus.busy);
    end
    @(negedge clk);
    bus.capture = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_index !== 4'd0 || bus.out_data !== 4'h1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_restart: got v=%b i=%0d d=%h b=%b dn=%b want v=1 i=0 d=1 b=1 dn=0", bus.out_valid, bus.out_index, bus.out_data, bus.busy, bus.done);
    end
    repeat (11) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: got b=%b want 0", bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_capture_busy();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/op_result_scanner.md
OP_RESULT_SCANNER -- requirements
Module: op_result_scanner

Interface
REQ-001 Parameter: W, 4, width of each result field and of the output data nibble.
REQ-002 Parameter: NFIELDS, 9, number of result fields captured per scan (fixed at 9 for this block).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: capture  input  1  request to latch all result fields and start a scan.
REQ-006 Ports: arithmetic, shift, relational, equality, bitwise, reduction, logical, concatenation, conditional  input  W each  result fields, field indices 0..8 in this order.
REQ-007 Port: out_valid  output  1  output beat available.
REQ-008 Port: out_ready  input  1  consumer accepts beat; transfer = out_valid && out_ready.
REQ-009 Port: out_data  output  W  current beat payload.
REQ-010 Port: out_index  output  4  current beat index, 0..8 fields, 9 checksum.
REQ-011 Port: out_last  output  1  high only on the checksum beat.
REQ-012 Port: busy  output  1  high in any state other than IDLE.
REQ-013 Port: done  output  1  one-cycle pulse after the checksum beat transfers.

Function
REQ-014 FSM states SHALL be IDLE, SEND, CSUM.
- IDLE -> SEND on capture.
- SEND -> CSUM on a transfer at index 8.
- CSUM -> IDLE on a transfer.
REQ-015 On capture in IDLE, all nine fields SHALL be latched on that edge.
- Checksum register := XOR of all nine inputs.
- Index := 0.
REQ-016 Latency: capture sampled at edge n SHALL give out_valid=1 with index 0 in the cycle after edge n.
REQ-017 In SEND, out_valid=1, out_data=latched field[index], out_last=0.
REQ-018 In CSUM, out_valid=1, out_data=checksum, out_index=9, out_last=1.
REQ-019 While out_valid && !out_ready, out_data, out_index and out_last SHALL hold stable.
REQ-020 Each transfer SHALL advance index by exactly one; no beat is skipped or repeated.
REQ-021 capture asserted while busy SHALL be ignored.
- Latched fields are not modified.
- The capture is not queued.
REQ-022 done SHALL pulse for exactly one cycle on the edge following the CSUM transfer; busy=0 in that cycle.
REQ-023 capture asserted in the same cycle done=1 SHALL start a new scan; FSM is already IDLE in that cycle.
REQ-024 Input field changes after capture SHALL NOT affect the scan in progress.
REQ-025 In IDLE, out_valid=0, out_data=0, out_index=0, out_last=0.

Reset
REQ-026 rst=1 SHALL immediately force, without waiting for clk:
- FSM to IDLE.
- out_valid, out_data, out_index, out_last, busy, done to 0.
- Latched fields and checksum to 0.
REQ-027 Reset mid-scan SHALL abandon the scan.
- No done pulse.
- First capture after rst deasserts starts a fresh scan from index 0.

Structure
REQ-028 A shared package SHALL hold:
- W and NFIELDS constants.
- Field index constants (ARITH_IDX=0 .. COND_IDX=8, CSUM_IDX=9).
- State encoding for IDLE/SEND/CSUM.
REQ-029 One sub-module, scan_field_mux, SHALL select latched field[index] combinationally; all other logic stays in op_result_scanner.

Verification
REQ-030 Basic scan: fields 0x1..0x9 in index order, out_ready=1, capture pulsed -> 10 consecutive beats.
- out_data 1,2,...,9 then checksum 0x1.
- out_last only on beat 10.
- done pulses one cycle after beat 10.
REQ-031 Backpressure: A=0xC field pattern (all fields 0xC), out_ready toggled 1,0,0,1,... -> out_data/out_index held during stalls; 10 beats total; checksum 0xC.
REQ-032 Capture while busy: second capture with different inputs at index 4 -> remaining beats carry the original values; exactly one done pulse.
REQ-033 Reset mid-scan: rst asserted at index 5 -> outputs 0 immediately with no done pulse; next capture restarts at index 0.
REQ-034 Back-to-back: capture held high through done -> second scan's index 0 appears the cycle after done.
